// File: rtl/eth_udp_tx_framer.sv
// eth_udp_tx_framer: wraps a 32-bit sample stream into fixed-length Ethernet/IPv4/UDP frames for the TSE MAC TX FIFO.
// Optional macro FRAMER_SEQNUM_EN inserts a per-frame sequence word between the UDP header and the payload.
module eth_udp_tx_framer #(
    parameter int PAYLOAD_WORDS = 256,
    parameter int IP_TTL        = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [47:0] cfg_dst_mac,
    input  logic [47:0] cfg_src_mac,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] ff_tx_data,
    output logic        ff_tx_sop,
    output logic        ff_tx_eop,
    output logic [1:0]  ff_tx_mod,
    output logic        ff_tx_err,
    output logic        ff_tx_crc_fwd,
    output logic        ff_tx_wren,
    input  logic        ff_tx_rdy,
    output logic        busy,
    output logic [15:0] frame_count
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CKSUM   = 3'd1,
        S_HDR     = 3'd2,
        S_SEQ     = 3'd3,
        S_PAYLOAD = 3'd4
    } state_t;

`ifdef FRAMER_SEQNUM_EN
    localparam int     SEQ_BYTES = 4;
    localparam state_t HDR_NEXT  = S_SEQ;
`else
    localparam int     SEQ_BYTES = 0;
    localparam state_t HDR_NEXT  = S_PAYLOAD;
`endif
    localparam int          P_BYTES = 4 * PAYLOAD_WORDS + SEQ_BYTES;
    localparam logic [15:0] IP_LEN  = 16'(28 + P_BYTES);
    localparam logic [15:0] UDP_LEN = 16'(8 + P_BYTES);
    localparam logic [8:0]  P_LAST  = 9'(PAYLOAD_WORDS - 1);
    localparam logic [7:0]  TTL     = 8'(IP_TTL);

    state_t      state_q, state_d;
    logic [3:0]  cyc_q, cyc_d;
    logic [3:0]  h_q, h_d;
    logic [8:0]  p_q, p_d;
    logic [19:0] acc_q, acc_d;
    logic [15:0] cksum_q, cksum_d;
    logic [47:0] dmac_q, dmac_d, smac_q, smac_d;
    logic [31:0] sip_q, sip_d, dip_q, dip_d;
    logic [15:0] sport_q, sport_d, dport_q, dport_d;
    logic [15:0] frame_count_q, frame_count_d;

    function automatic logic [15:0] cksum_term(input logic [3:0] cyc, input logic [15:0] ident,
                                               input logic [31:0] sip, input logic [31:0] dip);
        case (cyc)
            4'd0:    return 16'h4500;
            4'd1:    return IP_LEN;
            4'd2:    return ident;
            4'd3:    return 16'h4000;
            4'd4:    return {TTL, 8'h11};
            4'd5:    return sip[31:16];
            4'd6:    return sip[15:0];
            4'd7:    return dip[31:16];
            4'd8:    return dip[15:0];
            default: return 16'h0000;
        endcase
    endfunction

    // Two end-around-carry folds are enough for a sum of nine 16-bit terms.
    function automatic logic [15:0] fold_cksum(input logic [19:0] acc);
        logic [16:0] s1;
        logic [15:0] s2;
        s1 = {1'b0, acc[15:0]} + {13'h0000, acc[19:16]};
        s2 = s1[15:0] + {15'h0000, s1[16]};
        return ~s2;
    endfunction

    // Next-state and datapath register updates.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        h_d           = h_q;
        p_d           = p_q;
        acc_d         = acc_q;
        cksum_d       = cksum_q;
        dmac_d        = dmac_q;
        smac_d        = smac_q;
        sip_d         = sip_q;
        dip_d         = dip_q;
        sport_d       = sport_q;
        dport_d       = dport_q;
        frame_count_d = frame_count_q;
        case (state_q)
            S_IDLE: begin
                if (enable && s_valid) begin
                    state_d = S_CKSUM;
                    cyc_d   = 4'd0;
                    acc_d   = 20'h00000;
                    dmac_d  = cfg_dst_mac;
                    smac_d  = cfg_src_mac;
                    sip_d   = cfg_src_ip;
                    dip_d   = cfg_dst_ip;
                    sport_d = cfg_src_port;
                    dport_d = cfg_dst_port;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CKSUM: begin
                if (cyc_q == 4'd9) begin
                    cksum_d = fold_cksum(acc_q);
                    h_d     = 4'd0;
                    state_d = S_HDR;
                end else begin
                    acc_d = acc_q + {4'h0, cksum_term(cyc_q, frame_count_q, sip_q, dip_q)};
                    cyc_d = cyc_q + 4'd1;
                end
            end
            S_HDR: begin
                if (ff_tx_rdy && (h_q == 4'd10)) begin
                    p_d     = 9'd0;
                    state_d = HDR_NEXT;
                end else if (ff_tx_rdy) begin
                    h_d = h_q + 4'd1;
                end else begin
                    h_d = h_q;
                end
            end
            S_SEQ: begin
                if (ff_tx_rdy) begin
                    state_d = S_PAYLOAD;
                end else begin
                    state_d = S_SEQ;
                end
            end
            S_PAYLOAD: begin
                if (s_valid && ff_tx_rdy && (p_q == P_LAST)) begin
                    state_d       = S_IDLE;
                    frame_count_d = frame_count_q + 16'd1;
                end else if (s_valid && ff_tx_rdy) begin
                    p_d = p_q + 9'd1;
                end else begin
                    p_d = p_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset truncates any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cyc_q         <= 4'd0;
            h_q           <= 4'd0;
            p_q           <= 9'd0;
            acc_q         <= 20'h00000;
            cksum_q       <= 16'h0000;
            dmac_q        <= 48'h0;
            smac_q        <= 48'h0;
            sip_q         <= 32'h0;
            dip_q         <= 32'h0;
            sport_q       <= 16'h0000;
            dport_q       <= 16'h0000;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            h_q           <= h_d;
            p_q           <= p_d;
            acc_q         <= acc_d;
            cksum_q       <= cksum_d;
            dmac_q        <= dmac_d;
            smac_q        <= smac_d;
            sip_q         <= sip_d;
            dip_q         <= dip_d;
            sport_q       <= sport_d;
            dport_q       <= dport_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Output mux: header words come from latched fields, payload passes straight through.
    always_comb begin
        ff_tx_data = 32'h0;
        ff_tx_sop  = 1'b0;
        ff_tx_eop  = 1'b0;
        ff_tx_wren = 1'b0;
        s_ready    = 1'b0;
        case (state_q)
            S_HDR: begin
                ff_tx_wren = 1'b1;
                ff_tx_sop  = (h_q == 4'd0);
                case (h_q)
                    4'd0:    ff_tx_data = {16'h0000, dmac_q[47:32]};
                    4'd1:    ff_tx_data = dmac_q[31:0];
                    4'd2:    ff_tx_data = smac_q[47:16];
                    4'd3:    ff_tx_data = {smac_q[15:0], 16'h0800};
                    4'd4:    ff_tx_data = {16'h4500, IP_LEN};
                    4'd5:    ff_tx_data = {frame_count_q, 16'h4000};
                    4'd6:    ff_tx_data = {TTL, 8'h11, cksum_q};
                    4'd7:    ff_tx_data = sip_q;
                    4'd8:    ff_tx_data = dip_q;
                    4'd9:    ff_tx_data = {sport_q, dport_q};
                    4'd10:   ff_tx_data = {UDP_LEN, 16'h0000};
                    default: ff_tx_data = 32'h0;
                endcase
            end
            S_SEQ: begin
                ff_tx_wren = 1'b1;
                ff_tx_data = {16'h0000, frame_count_q};
            end
            S_PAYLOAD: begin
                ff_tx_data = s_data;
                ff_tx_wren = s_valid;
                s_ready    = ff_tx_rdy;
                ff_tx_eop  = (p_q == P_LAST);
            end
            default: ff_tx_data = 32'h0;
        endcase
    end

    assign ff_tx_mod     = 2'b00;
    assign ff_tx_err     = 1'b0;
    assign ff_tx_crc_fwd = 1'b0;
    assign busy          = (state_q != S_IDLE);
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_eth_udp_tx_framer.sv
// Scoreboard bench for eth_udp_tx_framer with PAYLOAD_WORDS=4; expected words are pushed by the
// stimulus and popped by an independent monitor on every word the DUT offers to the MAC.
module tb_eth_udp_tx_framer;
    localparam int PW = 4;
`ifdef FRAMER_SEQNUM_EN
    localparam logic [15:0] EXP_IP_LEN  = 16'h0030;
    localparam logic [15:0] EXP_UDP_LEN = 16'h001C;
    localparam logic [15:0] EXP_CK0     = 16'hB761;
`else
    localparam logic [15:0] EXP_IP_LEN  = 16'h002C;
    localparam logic [15:0] EXP_UDP_LEN = 16'h0018;
    localparam logic [15:0] EXP_CK0     = 16'hB765;
`endif

    logic        clk = 1'b0;
    logic        reset_n, enable, s_valid, s_ready, ff_tx_rdy, busy;
    logic [47:0] cfg_dst_mac, cfg_src_mac;
    logic [31:0] cfg_src_ip, cfg_dst_ip, s_data, ff_tx_data;
    logic [15:0] cfg_src_port, cfg_dst_port, frame_count;
    logic        ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_crc_fwd, ff_tx_wren;
    logic [1:0]  ff_tx_mod;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   tests = 0;
    int   fails = 0;
    int   widx  = 0;

    eth_udp_tx_framer #(.PAYLOAD_WORDS(PW), .IP_TTL(64)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
        .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
        .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ff_tx_data(ff_tx_data), .ff_tx_sop(ff_tx_sop), .ff_tx_eop(ff_tx_eop),
        .ff_tx_mod(ff_tx_mod), .ff_tx_err(ff_tx_err), .ff_tx_crc_fwd(ff_tx_crc_fwd),
        .ff_tx_wren(ff_tx_wren), .ff_tx_rdy(ff_tx_rdy), .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pay_word(input int fr, input int i);
        return {16'hD00D, 8'(fr), 8'(i)};
    endfunction

    function automatic logic [31:0] hdr_word(input int h, input logic [15:0] ident);
        case (h)
            0:       return 32'h0000_0011;
            1:       return 32'h2233_4455;
            2:       return 32'h0A0B_0C0D;
            3:       return 32'h0E0F_0800;
            4:       return {16'h4500, EXP_IP_LEN};
            5:       return {ident, 16'h4000};
            6:       return {16'h4011, EXP_CK0 - ident};
            7:       return 32'hC0A8_010A;
            8:       return 32'hC0A8_0101;
            9:       return 32'h04D2_162E;
            10:      return {EXP_UDP_LEN, 16'h0000};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: every offered word must match the head of the scoreboard; pop when the MAC accepts it.
    always @(negedge clk) begin
        if (reset_n && ff_tx_wren) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: got data=%h sop=%b eop=%b, expected no word", ff_tx_data, ff_tx_sop, ff_tx_eop);
            end else begin
                e_mon = exp_q[0];
                if ({ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_crc_fwd} !==
                    {e_mon.data, e_mon.sop, e_mon.eop, 2'b00, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL tx_word[%0d]: got data=%h sop=%b eop=%b mod=%b err=%b fwd=%b, expected data=%h sop=%b eop=%b",
                             widx, ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, ff_tx_crc_fwd,
                             e_mon.data, e_mon.sop, e_mon.eop);
                end
                if (ff_tx_rdy) begin
                    void'(exp_q.pop_front());
                    widx = e_mon.sop ? 1 : widx + 1;
                end
            end
        end
    end

    task automatic do_reset_check();
        reset_n = 1'b0;
        #1;
        check("reset_outputs_zero",
              {7'h0, ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_mod, ff_tx_err, ff_tx_crc_fwd, s_ready, busy, frame_count},
              64'h0);
        exp_q.delete();
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic send_frame(input int fr, input logic [15:0] ident, input bit stall, input bit gap,
                              input bit drop_en, input int reset_at);
        exp_t e;
        for (int h = 0; h < 11; h++) begin
            e.data = hdr_word(h, ident); e.sop = (h == 0); e.eop = 1'b0;
            exp_q.push_back(e);
        end
`ifdef FRAMER_SEQNUM_EN
        e.data = {16'h0000, ident}; e.sop = 1'b0; e.eop = 1'b0;
        exp_q.push_back(e);
`endif
        for (int i = 0; i < PW; i++) begin
            e.data = pay_word(fr, i); e.sop = 1'b0; e.eop = (i == PW - 1);
            exp_q.push_back(e);
        end
        fork
            begin
                for (int i = 0; i < PW; i++) begin
                    int n;
                    if (i == reset_at) begin
                        do_reset_check();
                        break;
                    end
                    s_data  = pay_word(fr, i);
                    s_valid = 1'b1;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!s_ready && n < 100);
                    if (!s_ready) begin
                        check("s_ready_timeout", 64'(n), 64'd0);
                        break;
                    end
                    @(posedge clk);
                    #1;
                    if (drop_en && i == 0) enable = 1'b0;
                    if (gap && i == 1) begin
                        s_valid = 1'b0;
                        repeat (2) begin
                            @(negedge clk);
                            check("gap_wren_low", 64'(ff_tx_wren), 64'd0);
                            @(posedge clk);
                            #1;
                        end
                    end
                end
            end
            begin
                if (stall) begin
                    int n;
                    n = 0;
                    do begin
                        @(negedge clk);
                        #1;
                        n++;
                    end while (!(widx == 6 && ff_tx_wren) && n < 200);
                    if (n >= 200) check("stall_arm_timeout", 64'(n), 64'd0);
                    @(posedge clk);
                    #1;
                    ff_tx_rdy = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check("stall_wren_held", {63'h0, ff_tx_wren}, 64'd1);
                    end
                    @(posedge clk);
                    #1;
                    ff_tx_rdy = 1'b1;
                end
            end
        join
    endtask

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b0;
        s_valid      = 1'b0;
        s_data       = 32'h0;
        ff_tx_rdy    = 1'b1;
        cfg_dst_mac  = 48'h0011_2233_4455;
        cfg_src_mac  = 48'h0A0B_0C0D_0E0F;
        cfg_src_ip   = 32'hC0A8_010A;
        cfg_dst_ip   = 32'hC0A8_0101;
        cfg_src_port = 16'd1234;
        cfg_dst_port = 16'd5678;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              {7'h0, ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_mod, ff_tx_err, ff_tx_crc_fwd, s_ready, busy, frame_count},
              64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Two frames back-to-back; the second one stalls the MAC and gaps the payload.
        send_frame(0, 16'd0, 1'b0, 1'b0, 1'b0, -1);
        send_frame(1, 16'd1, 1'b1, 1'b1, 1'b0, -1);
        @(negedge clk);
        check("frame_count_after_two", 64'(frame_count), 64'd2);

        // enable dropped mid-frame: frame finishes, no further sop while s_valid stays high.
        send_frame(2, 16'd2, 1'b0, 1'b0, 1'b1, -1);
        repeat (30) @(negedge clk);
        check("idle_after_enable_drop", {47'h0, busy, frame_count}, {47'h0, 1'b0, 16'd3});

        // Reset during payload word 2, then a clean frame restarting at ident 0.
        enable = 1'b1;
        send_frame(3, 16'd3, 1'b0, 1'b0, 1'b0, 2);
        #1;
        check("frame_count_after_reset", 64'(frame_count), 64'd0);
        send_frame(4, 16'd0, 1'b0, 1'b0, 1'b0, -1);
        s_valid = 1'b0;
        enable  = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("frame_count_final", 64'(frame_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
